// File: rtl/vx_cmt_counters.sv
// vx_cmt_counters: 64-bit mcycle / minstret performance counters exposed as
// 32-bit CSR halves, with a single-entry buffered read port and a write port.
// Optional build macro PERF_SNAPSHOT_EN: a low-half read latches the upper
// half of the same counter into a shadow register, and high-half reads return
// that shadow so software sees a consistent 64-bit value across two reads.

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module vx_cmt_counters #(
  parameter int CORE_ID = 0,
  parameter int CNT_W   = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmt_valid,
  input  logic [$clog2(`NUM_THREADS+1)-1:0] commit_size,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [11:0]                      req_addr,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_data,
  input  logic                             wr_valid,
  input  logic [11:0]                      wr_addr,
  input  logic [31:0]                      wr_data
);

  localparam int CS_W = $clog2(`NUM_THREADS+1);

  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] U_MCYCLE    = 12'hC00;
  localparam logic [11:0] U_MCYCLEH   = 12'hC80;
  localparam logic [11:0] U_MINSTRET  = 12'hC02;
  localparam logic [11:0] U_MINSTRETH = 12'hC82;

  // The core index only tags debug traces; negative indices carry no meaning.
  if (CORE_ID < 0) begin : g_core_id_unused
  end

  logic [CNT_W-1:0] mcycle_q,   mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q,  rsp_data_d;
  logic [31:0]      rd_data;
  logic [31:0]      mcycle_hi, minstret_hi;
  logic             req_fire;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign req_fire  = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef PERF_SNAPSHOT_EN
  logic [31:0] snap_mcycle_q,   snap_mcycle_d;
  logic [31:0] snap_minstret_q, snap_minstret_d;

  assign mcycle_hi   = snap_mcycle_q;
  assign minstret_hi = snap_minstret_q;

  // Latch the live upper half whenever the matching low half is read.
  always_comb begin
    snap_mcycle_d   = snap_mcycle_q;
    snap_minstret_d = snap_minstret_q;
    if (req_fire) begin
      if (req_addr == A_MCYCLE || req_addr == U_MCYCLE)
        snap_mcycle_d = mcycle_q[CNT_W-1:32];
      if (req_addr == A_MINSTRET || req_addr == U_MINSTRET)
        snap_minstret_d = minstret_q[CNT_W-1:32];
    end
  end

  // Shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_mcycle_q   <= '0;
      snap_minstret_q <= '0;
    end else begin
      snap_mcycle_q   <= snap_mcycle_d;
      snap_minstret_q <= snap_minstret_d;
    end
  end
`else
  assign mcycle_hi   = mcycle_q[CNT_W-1:32];
  assign minstret_hi = minstret_q[CNT_W-1:32];
`endif

  // Counter next state: increment, overridden by a write to either half.
  always_comb begin
    mcycle_d   = mcycle_q + CNT_W'(1);
    minstret_d = minstret_q;
    if (cmt_valid)
      minstret_d = minstret_q + {{(CNT_W-CS_W){1'b0}}, commit_size};
    if (wr_valid) begin
      case (wr_addr)
        A_MCYCLE:    mcycle_d   = {mcycle_q[CNT_W-1:32], wr_data};
        A_MCYCLEH:   mcycle_d   = {wr_data, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[CNT_W-1:32], wr_data};
        A_MINSTRETH: minstret_d = {wr_data, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // Read mux over the pre-update counter values.
  always_comb begin
    rd_data = '0;
    case (req_addr)
      A_MCYCLE,    U_MCYCLE:    rd_data = mcycle_q[31:0];
      A_MCYCLEH,   U_MCYCLEH:   rd_data = mcycle_hi;
      A_MINSTRET,  U_MINSTRET:  rd_data = minstret_q[31:0];
      A_MINSTRETH, U_MINSTRETH: rd_data = minstret_hi;
      default: ;
    endcase
  end

  // Single-entry response buffer: load on accept, drop on consume, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Counter and response state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q    <= '0;
      minstret_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_vx_cmt_counters.sv
// Directed bench for vx_cmt_counters with a response scoreboard.

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

module tb_vx_cmt_counters;

  localparam int NT   = `NUM_THREADS;
  localparam int CS_W = $clog2(NT+1);

  logic            clk = 1'b0;
  logic            reset;
  logic            cmt_valid;
  logic [CS_W-1:0] commit_size;
  logic            req_valid;
  logic            req_ready;
  logic [11:0]     req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic            wr_valid;
  logic [11:0]     wr_addr;
  logic [31:0]     wr_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  vx_cmt_counters #(.CORE_ID(0), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .cmt_valid(cmt_valid), .commit_size(commit_size),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge where a response is expected to be presented.
  task automatic collect();
    exp_t e;
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) check(e.tag, rsp_data, e.data);
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input bit chk, input string tag);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    sb.push_back('{e, chk, tag});
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    collect();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic commit(input logic [CS_W-1:0] sz);
    @(negedge clk);
    cmt_valid   = 1'b1;
    commit_size = sz;
    @(posedge clk);
    #1 cmt_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmt_valid = 1'b0; commit_size = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    reset = 1'b0;

    // Ten idle cycles then mcycle low read
    repeat (10) @(posedge clk);
    rd(12'hB00, 32'd10, 1'b1, "mcycle_after_10");

    // mcycle write wins over increment
    wr(12'hB00, 32'h100);
    rd(12'hB00, 32'h100, 1'b1, "mcycle_wr_low");
    rd(12'hB80, 32'h0,   1'b1, "mcycle_hi_zero");

    // Same-cycle read and write of mcycle high
    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'hB80;
    wr_valid  = 1'b1; wr_addr  = 12'hB80; wr_data = 32'h5;
    sb.push_back('{32'h0, 1'b1, "rw_same_old"});
    @(posedge clk);
    #1 begin req_valid = 1'b0; wr_valid = 1'b0; end
    @(negedge clk);
    collect();
    rd(12'hB00, 32'h0, 1'b0, "mcycle_lo_latch");
    rd(12'hB80, 32'h5, 1'b1, "mcycle_hi_written");
    wr(12'hC80, 32'h7);
    rd(12'hB00, 32'h0, 1'b0, "mcycle_lo_latch2");
    rd(12'hB80, 32'h5, 1'b1, "mcycle_hi_user_wr_ignored");

    // Commits 4, 0, NT on consecutive cycles
    @(negedge clk);
    cmt_valid = 1'b1; commit_size = CS_W'(4);
    @(negedge clk);
    commit_size = '0;
    @(negedge clk);
    commit_size = CS_W'(NT);
    @(negedge clk);
    cmt_valid = 1'b0;
    rd(12'hB02, 32'(4 + NT), 1'b1, "minstret_sum");
    rd(12'hB82, 32'h0,       1'b1, "minstret_hi_zero");

    // 64-bit wrap
    wr(12'hB02, 32'hFFFF_FFFF);
    wr(12'hB82, 32'hFFFF_FFFF);
    commit(CS_W'(2));
    rd(12'hB02, 32'h1, 1'b1, "minstret_wrap_lo");
    rd(12'hB82, 32'h0, 1'b1, "minstret_wrap_hi");

    // Snapshot behaviour across a low-to-high carry
    wr(12'hB82, 32'h0);
    wr(12'hB02, 32'hFFFF_FFFF);
    rd(12'hB02, 32'hFFFF_FFFF, 1'b1, "snap_lo");
    commit(CS_W'(1));
`ifdef PERF_SNAPSHOT_EN
    rd(12'hB82, 32'h0, 1'b1, "snap_hi_shadow");
`else
    rd(12'hB82, 32'h1, 1'b1, "snap_hi_live");
`endif

    // Write precedence over a same-cycle commit
    @(negedge clk);
    wr_valid  = 1'b1; wr_addr = 12'hB02; wr_data = 32'h10;
    cmt_valid = 1'b1; commit_size = CS_W'(3);
    @(posedge clk);
    #1 begin wr_valid = 1'b0; cmt_valid = 1'b0; end
    rd(12'hB02, 32'h10, 1'b1, "minstret_wr_precedence");
    rd(12'hC82, 32'h1,  1'b1, "alias_c82");
    rd(12'h123, 32'h0,  1'b1, "unmapped_zero");
    rd(12'hC02, 32'h10, 1'b1, "alias_c02");
    wr(12'hC02, 32'hAB);
    rd(12'hB02, 32'h10, 1'b1, "user_wr_ignored");

    // Backpressure: response held, request stalled, then same-cycle accept
    commit(CS_W'(3));
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 12'hB02;
    sb.push_back('{32'h13, 1'b1, "bp_first"});
    @(posedge clk);
    #1 req_addr = 12'hB82;
    sb.push_back('{32'h1, 1'b1, "bp_second"});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
      check("bp_rsp_valid",     {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_stable",    rsp_data, 32'h13);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_req_ready_high", {31'b0, req_ready}, 32'd1);
    collect();
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    collect();

    // Reset with a pending response and active strobes
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 12'hB02;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cmt_valid = 1'b1; commit_size = CS_W'(4);
    wr_valid  = 1'b1; wr_addr = 12'hB02; wr_data = 32'h55;
    repeat (2) @(negedge clk);
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_rsp_data",  rsp_data, 32'd0);
    reset = 1'b0; cmt_valid = 1'b0; wr_valid = 1'b0; rsp_ready = 1'b1;
    sb.delete();
    rd(12'hB00, 32'h1, 1'b1, "post_rst_mcycle");
    rd(12'hB02, 32'h0, 1'b1, "post_rst_minstret");
    rd(12'hB82, 32'h0, 1'b1, "post_rst_minstret_hi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
